// File: rtl/pwm_actuator.sv
// Double-buffered PWM driver for the plant actuator. Duty and prescale shadows
// reload only at period boundaries, flagged by a one-cycle period_start strobe.
module pwm_actuator #(
   parameter logic [7:0] CNT_MAX = 8'd254
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] duty_in,
   input  logic [7:0] prescale,
   output logic       pwm_out,
   output logic       period_start,
   output logic [7:0] duty_active,
   output logic       active
);

   typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

   state_e     state_q, state_d;
   logic [7:0] pre_cnt_q, pre_cnt_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] duty_q, duty_d;
   logic [7:0] prescale_q, prescale_d;
   logic       pwm_q, pwm_d;
   logic       start_q, start_d;
   logic       active_q, active_d;

   logic tick;
   logic boundary;

   assign tick     = (state_q != StIdle) && (pre_cnt_q == prescale_q);
   assign boundary = tick && (cnt_q == CNT_MAX);

   always_comb begin
      state_d    = state_q;
      pre_cnt_d  = pre_cnt_q;
      cnt_d      = cnt_q;
      duty_d     = duty_q;
      prescale_d = prescale_q;
      start_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            pre_cnt_d = 8'd0;
            cnt_d     = 8'd0;
            if (en) begin
               state_d    = StRun;
               duty_d     = duty_in;
               prescale_d = prescale;
               start_d    = 1'b1;
            end
         end
         StRun, StStop: begin
            pre_cnt_d = tick ? 8'd0 : pre_cnt_q + 8'd1;
            if (tick) begin
               cnt_d = boundary ? 8'd0 : cnt_q + 8'd1;
            end
            // Boundary is judged on the current state, so a RUN boundary that
            // coincides with en falling still relatches before entering STOP.
            if (boundary && (state_q == StStop)) begin
               state_d = StIdle;
            end else begin
               state_d = en ? StRun : StStop;
            end
            if (boundary && (state_q == StRun)) begin
               duty_d     = duty_in;
               prescale_d = prescale;
               start_d    = 1'b1;
            end
         end
         default: begin
            state_d   = StIdle;
            pre_cnt_d = 8'd0;
            cnt_d     = 8'd0;
         end
      endcase

      // Outputs are computed from next-state values so the registered output
      // matches the counters of the same cycle, with no extra latency.
      active_d = (state_d != StIdle);
      pwm_d    = active_d && (cnt_d < duty_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         pre_cnt_q  <= 8'd0;
         cnt_q      <= 8'd0;
         duty_q     <= 8'd0;
         prescale_q <= 8'd0;
         pwm_q      <= 1'b0;
         start_q    <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         cnt_q      <= cnt_d;
         duty_q     <= duty_d;
         prescale_q <= prescale_d;
         pwm_q      <= pwm_d;
         start_q    <= start_d;
         active_q   <= active_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = start_q;
   assign duty_active  = duty_q;
   assign active       = active_q;

endmodule

// File: doc/pwm_actuator.md
Name: pwm_actuator

Overview:
Actuator-side companion to the PID controller. Consumes the controller's 8-bit control word as a duty command and drives a single PWM output to the plant. Duty and prescale are double-buffered and applied only at period boundaries. A one-cycle period_start strobe marks each boundary so the control loop can sample feedback and update the duty in lock-step with the PWM period.

Parameters:
CNT_MAX, 8'd254, last value of the period counter; a period is CNT_MAX+1 = 255 ticks, so duty 0 means always low and 255 means always high.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
en  input  1  run request; level-sensitive
duty_in  input  8  duty command from the controller's control_out; unsigned, in ticks high per period
prescale  input  8  tick divider; one tick every prescale+1 clocks
pwm_out  output  1  PWM drive to the plant
period_start  output  1  one-cycle strobe in the first clock of every period
duty_active  output  8  duty value currently applied (shadow register)
active  output  1  high while in RUN or STOP

Behaviour:
- Reset: rst=1 at a rising edge sets all of the following to 0 on that edge: state=IDLE, pre_cnt, cnt, duty_active, prescale_active, pwm_out, period_start, active. Reset has priority over everything and aborts a period mid-way; there is no completion.
- States: IDLE, RUN, STOP.
- IDLE:
  - pwm_out=0, active=0, counters held at 0.
  - en=1 leads to RUN on the next edge. On that same edge: latch duty_in into duty_active and prescale into prescale_active, set cnt=0 and pre_cnt=0, and set period_start=1 for that one cycle.
- Tick generation (RUN/STOP):
  - pre_cnt increments each clock.
  - When pre_cnt==prescale_active, pre_cnt returns to 0 and tick=1 for that cycle.
  - With prescale_active=0, tick=1 every clock.
- Period counter: advances on tick. On tick with cnt==CNT_MAX, cnt wraps to 0, which is the boundary.
- Boundary in RUN: relatch duty_active<=duty_in and prescale_active<=prescale, and set period_start=1 in the following cycle (the cycle where cnt=0 first appears).
- Boundary in STOP: go to IDLE. No relatch and no period_start. pwm_out=0 from then on.
- RUN with en=0: go to STOP immediately; the current period continues unchanged.
- STOP with en=1: return to RUN with no disturbance to the counters; the next boundary relatches normally.
- pwm_out is registered:
  - pwm_out=1 in every cycle where state is RUN or STOP and cnt < duty_active, evaluated on the registered values of that cycle.
  - High time per period = duty_active*(prescale_active+1) clocks.
  - Period length = 255*(prescale_active+1) clocks.
  - In the first cycle of RUN after IDLE, pwm_out reflects the newly latched duty, with no extra latency.
- duty_in and prescale changes mid-period are ignored until the next boundary.
- Simultaneous en fall and boundary in RUN: the boundary is evaluated with the old state (RUN), so the block relatches and strobes, then enters STOP.
- period_start is never asserted in two consecutive cycles, except when CNT_MAX ticks elapse in one clock, which cannot occur.
- active=1 iff state is RUN or STOP.
- Arithmetic: all counters are unsigned 8-bit. No signed values and no saturation are needed; duty is 0..255 by construction.

Test Plan:
1. rst held 3 cycles, then en=1, prescale=0, duty_in=128 -> period_start on the first RUN cycle and every 255 clocks after; pwm_out high 128 clocks then low 127; duty_active=128; active=1.
2. duty_in=0, then a later run with duty_in=255 (prescale=0) -> pwm_out constantly 0 over 3 periods; then constantly 1 over 3 periods, with no low cycle at boundaries.
3. Running at duty=128; change duty_in to 64 at cnt=30 -> the current period stays at 128 high clocks; duty_active becomes 64 at the boundary; the next period has 64 high clocks.
4. prescale=3, duty_in=10 -> pwm_out high 40 clocks; period 1020 clocks; period_start spacing 1020.
5. en dropped at cnt=100 (duty=200, prescale=0) -> the period completes (pwm high through cnt=199); then IDLE at the boundary; no period_start; pwm_out=0; active=0. Variant: en re-raised at cnt=150 -> stays running; period_start at the boundary.
6. rst pulsed for 1 cycle at cnt=50 in RUN with en=1 -> all outputs 0 on that edge; the next edge re-enters RUN with a fresh latch and period_start.
